// File: rtl/mpq_host.sv
// mpq_host: buffers a data list and a command script, streams them into the
// max-priority-queue engine, and captures the engine's RAM write-back for readback.
module mpq_host #(
  parameter int DATA_DEPTH   = 32,
  parameter int SCRIPT_DEPTH = 16,
  parameter int WDOG_CYCLES  = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld_valid,
  output logic       ld_ready,
  input  logic [7:0] ld_data,
  input  logic       ld_last,
  input  logic       sc_valid,
  output logic       sc_ready,
  input  logic [2:0] sc_cmd,
  input  logic [7:0] sc_index,
  input  logic [7:0] sc_value,
  input  logic       sc_last,
  output logic       mpq_data_valid,
  output logic [7:0] mpq_data,
  output logic       mpq_cmd_valid,
  output logic [2:0] mpq_cmd,
  output logic [7:0] mpq_index,
  output logic [7:0] mpq_value,
  input  logic       mpq_busy,
  input  logic       mpq_ram_valid,
  input  logic [7:0] mpq_ram_a,
  input  logic [7:0] mpq_ram_d,
  input  logic       mpq_done,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [5:0] heap_size,
  output logic       finished,
  output logic       err
);
  localparam int DW  = $clog2(DATA_DEPTH);
  localparam int DCW = $clog2(DATA_DEPTH + 1);
  localparam int SW  = $clog2(SCRIPT_DEPTH);
  localparam int SCW = $clog2(SCRIPT_DEPTH + 1);
  localparam int WW  = $clog2(WDOG_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_COLLECT = 3'd0,
    ST_STREAM  = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_FINISH  = 3'd4,
    ST_ERROR   = 3'd5
  } state_t;

  state_t         state_r, state_s;
  logic [7:0]     data_mem_r  [DATA_DEPTH];
  logic [7:0]     res_mem_r   [DATA_DEPTH];
  logic [2:0]     scr_cmd_r   [SCRIPT_DEPTH];
  logic [7:0]     scr_index_r [SCRIPT_DEPTH];
  logic [7:0]     scr_value_r [SCRIPT_DEPTH];
  logic [DCW-1:0] ld_cnt_r;
  logic           ld_done_r;
  logic [SCW-1:0] sc_cnt_r;
  logic           sc_done_r;
  logic [DW-1:0]  str_idx_r;
  logic [SW-1:0]  iss_idx_r;
  logic [WW-1:0]  wdog_r;
  logic [5:0]     heap_size_r;
  logic [7:0]     rd_data_r;

  logic ld_ready_s, sc_ready_s, ld_acc_s, sc_acc_s, ld_ovf_s, sc_bad_s;
  logic ld_fin_s, sc_fin_s, stream_last_s, cmd_fire_s, issue_last_s;
  logic cap_bad_s, cap_wr_s, wdog_exp_s, ld_store_s, sc_store_s;

  assign ld_ready_s    = (state_r == ST_COLLECT) && !ld_done_r;
  assign sc_ready_s    = (state_r == ST_COLLECT) && !sc_done_r;
  assign ld_acc_s      = ld_valid && ld_ready_s;
  assign sc_acc_s      = sc_valid && sc_ready_s;
  assign ld_ovf_s      = ld_acc_s && (ld_cnt_r == DCW'(DATA_DEPTH));
  assign sc_bad_s      = sc_acc_s && ((sc_cnt_r == SCW'(SCRIPT_DEPTH)) || (sc_cmd > 3'd4) ||
                                      (sc_last && (sc_cmd != 3'd4)));
  assign ld_store_s    = ld_acc_s && !ld_ovf_s;
  assign sc_store_s    = sc_acc_s && !sc_bad_s;
  assign ld_fin_s      = ld_done_r || (ld_acc_s && ld_last);
  assign sc_fin_s      = sc_done_r || (sc_acc_s && sc_last);
  assign stream_last_s = (DCW'(str_idx_r) == (ld_cnt_r - DCW'(1)));
  // The engine's ready window is a single busy-low cycle, so the command strobe cannot wait a cycle.
  assign cmd_fire_s    = (state_r == ST_ISSUE) && !mpq_busy;
  assign issue_last_s  = cmd_fire_s && (scr_cmd_r[iss_idx_r] == 3'd4);
  assign cap_bad_s     = (state_r == ST_CAPTURE) && mpq_ram_valid && (mpq_ram_a >= 8'(DATA_DEPTH));
  assign cap_wr_s      = (state_r == ST_CAPTURE) && mpq_ram_valid && !cap_bad_s;
  assign wdog_exp_s    = (wdog_r >= WW'(WDOG_CYCLES - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_COLLECT;
    else     state_r <= state_s;
  end

  // Next-state selection
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_COLLECT: begin
        if (ld_ovf_s || sc_bad_s)      state_s = ST_ERROR;
        else if (ld_fin_s && sc_fin_s) state_s = ST_STREAM;
        else                           state_s = ST_COLLECT;
      end
      ST_STREAM: begin
        if (stream_last_s) state_s = ST_ISSUE;
        else               state_s = ST_STREAM;
      end
      ST_ISSUE: begin
        if (issue_last_s)                    state_s = ST_CAPTURE;
        else if (wdog_exp_s && !cmd_fire_s) state_s = ST_ERROR;
        else                                 state_s = ST_ISSUE;
      end
      ST_CAPTURE: begin
        if (cap_bad_s)       state_s = ST_ERROR;
        else if (mpq_done)   state_s = ST_FINISH;
        else if (wdog_exp_s) state_s = ST_ERROR;
        else                 state_s = ST_CAPTURE;
      end
      ST_FINISH: state_s = ST_FINISH;
      ST_ERROR:  state_s = ST_ERROR;
      default:   state_s = ST_ERROR;
    endcase
  end

  // Watchdog: cleared on any state change or accepted command
  always_ff @(posedge clk) begin
    if (rst || (state_s != state_r) || cmd_fire_s)
      wdog_r <= '0;
    else if ((state_r == ST_ISSUE) || (state_r == ST_CAPTURE))
      wdog_r <= wdog_r + WW'(1);
    else
      wdog_r <= '0;
  end

  // Collection counters and last-beat flags
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_cnt_r  <= '0;
      ld_done_r <= 1'b0;
      sc_cnt_r  <= '0;
      sc_done_r <= 1'b0;
    end else begin
      if (ld_store_s) begin
        ld_cnt_r  <= ld_cnt_r + DCW'(1);
        ld_done_r <= ld_last;
      end
      if (sc_store_s) begin
        sc_cnt_r  <= sc_cnt_r + SCW'(1);
        sc_done_r <= sc_last;
      end
    end
  end

  // Data and script buffers (contents need no reset)
  always_ff @(posedge clk) begin
    if (ld_store_s) data_mem_r[ld_cnt_r[DW-1:0]] <= ld_data;
    if (sc_store_s) begin
      scr_cmd_r[sc_cnt_r[SW-1:0]]   <= sc_cmd;
      scr_index_r[sc_cnt_r[SW-1:0]] <= sc_index;
      scr_value_r[sc_cnt_r[SW-1:0]] <= sc_value;
    end
  end

  // Stream and issue pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      str_idx_r <= '0;
      iss_idx_r <= '0;
    end else begin
      if (state_r == ST_STREAM) str_idx_r <= str_idx_r + DW'(1);
      else                      str_idx_r <= '0;
      if (cmd_fire_s) iss_idx_r <= iss_idx_r + SW'(1);
    end
  end

  // Result capture count and registered readback
  always_ff @(posedge clk) begin
    if (rst) begin
      heap_size_r <= 6'd0;
      rd_data_r   <= 8'd0;
    end else begin
      if (cap_wr_s) heap_size_r <= heap_size_r + 6'd1;
      rd_data_r <= res_mem_r[rd_addr];
    end
  end

  // Result RAM write port
  always_ff @(posedge clk) begin
    if (cap_wr_s) res_mem_r[mpq_ram_a[DW-1:0]] <= mpq_ram_d;
  end

  assign ld_ready       = ld_ready_s;
  assign sc_ready       = sc_ready_s;
  assign mpq_data_valid = (state_r == ST_STREAM);
  assign mpq_data       = (state_r == ST_STREAM) ? data_mem_r[str_idx_r] : 8'd0;
  assign mpq_cmd_valid  = cmd_fire_s;
  assign mpq_cmd        = (state_r == ST_ISSUE) ? scr_cmd_r[iss_idx_r]   : 3'd0;
  assign mpq_index      = (state_r == ST_ISSUE) ? scr_index_r[iss_idx_r] : 8'd0;
  assign mpq_value      = (state_r == ST_ISSUE) ? scr_value_r[iss_idx_r] : 8'd0;
  assign rd_data        = rd_data_r;
  assign heap_size      = heap_size_r;
  assign finished       = (state_r == ST_FINISH);
  assign err            = (state_r == ST_ERROR);
endmodule

// File: tb/tb_mpq_host.sv
// Bench for mpq_host: a scripted engine stub answers the host, scoreboard queues
// hold the expected data burst and command sequence.
module tb_mpq_host;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ld_valid = 1'b0, ld_ready, ld_last = 1'b0;
  logic [7:0] ld_data = 8'd0;
  logic       sc_valid = 1'b0, sc_ready, sc_last = 1'b0;
  logic [2:0] sc_cmd = 3'd0;
  logic [7:0] sc_index = 8'd0, sc_value = 8'd0;
  logic       mpq_data_valid, mpq_cmd_valid;
  logic [7:0] mpq_data, mpq_index, mpq_value;
  logic [2:0] mpq_cmd;
  logic       busy, ram_valid, done;
  logic [7:0] ram_a, ram_d;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_data;
  logic [5:0] heap_size;
  logic       finished, err;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  logic [7:0]  d_a [40];
  logic [18:0] s_a [16];
  logic [7:0]  rsp [32];
  int          nr = 0;
  logic [7:0]  exp_data [$];
  logic [18:0] exp_cmd  [$];
  logic [7:0]  obs_data [$];
  logic [18:0] obs_cmd  [$];
  int dv_rises, cv_bad, missed, eph, etmr, ewr;
  logic dv_prev;

  mpq_host dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .sc_valid(sc_valid), .sc_ready(sc_ready), .sc_cmd(sc_cmd), .sc_index(sc_index),
    .sc_value(sc_value), .sc_last(sc_last),
    .mpq_data_valid(mpq_data_valid), .mpq_data(mpq_data), .mpq_cmd_valid(mpq_cmd_valid),
    .mpq_cmd(mpq_cmd), .mpq_index(mpq_index), .mpq_value(mpq_value), .mpq_busy(busy),
    .mpq_ram_valid(ram_valid), .mpq_ram_a(ram_a), .mpq_ram_d(ram_d), .mpq_done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .heap_size(heap_size),
    .finished(finished), .err(err)
  );

  always #5 clk = ~clk;

  // Engine stub: one-cycle busy-low windows, then replays rsp[] as RAM writes
  always @(posedge clk) begin
    if (rst) begin
      eph <= 0; etmr <= 0; ewr <= 0; busy <= 1'b1; ram_valid <= 1'b0; done <= 1'b0;
      ram_a <= 8'd0; ram_d <= 8'd0; dv_prev <= 1'b0; dv_rises <= 0; cv_bad <= 0; missed <= 0;
      obs_data.delete(); obs_cmd.delete();
    end else begin
      ram_valid <= 1'b0; done <= 1'b0; dv_prev <= mpq_data_valid;
      if (mpq_data_valid) obs_data.push_back(mpq_data);
      if (mpq_data_valid && !dv_prev) dv_rises <= dv_rises + 1;
      if (mpq_cmd_valid && busy) cv_bad <= cv_bad + 1;
      case (eph)
        0: if (dv_prev && !mpq_data_valid) begin eph <= 1; etmr <= 3; end
        1: if (etmr <= 1) begin busy <= 1'b0; eph <= 2; end else etmr <= etmr - 1;
        2: begin
          busy <= 1'b1;
          if (mpq_cmd_valid) begin
            obs_cmd.push_back({mpq_cmd, mpq_index, mpq_value});
            if (mpq_cmd == 3'd4) begin eph <= 3; etmr <= 2; end
            else begin eph <= 1; etmr <= 3; end
          end else begin
            missed <= missed + 1; eph <= 1; etmr <= 3;
          end
        end
        3: if (etmr <= 1) begin eph <= 4; ewr <= 0; end else etmr <= etmr - 1;
        4: begin
          ram_valid <= 1'b1; ram_a <= 8'(ewr); ram_d <= rsp[ewr];
          if (ewr == nr - 1) begin done <= 1'b1; eph <= 5; end
          ewr <= ewr + 1;
        end
        default: ;
      endcase
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ld_valid = 1'b0; sc_valid = 1'b0; ld_last = 1'b0; sc_last = 1'b0;
    exp_data.delete(); exp_cmd.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drive_job(input int nd, input int ns);
    int n;
    n = (nd > ns) ? nd : ns;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      ld_valid = (k < nd); ld_data = (k < nd) ? d_a[k] : 8'd0; ld_last = (k == nd - 1);
      sc_valid = (k < ns); sc_last = (k == ns - 1);
      {sc_cmd, sc_index, sc_value} = (k < ns) ? s_a[k] : 19'd0;
      if (k < nd) exp_data.push_back(d_a[k]);
      if (k < ns) exp_cmd.push_back(s_a[k]);
    end
    @(negedge clk);
    ld_valid = 1'b0; sc_valid = 1'b0; ld_last = 1'b0; sc_last = 1'b0;
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    while (!finished && !err && t < 1000) begin @(negedge clk); t++; end
    chk_cnt++;
    if (t >= 1000) $display("FAIL wait_end: timed out after %0d cycles", t); else pass_cnt++;
  endtask

  task automatic check_job(input int nd);
    logic [7:0]  ed;
    logic [18:0] ec;
    int nc;
    chk_cnt++;
    if (obs_data.size() != nd) $display("FAIL burst_len: got %0d want %0d", obs_data.size(), nd);
    else pass_cnt++;
    for (int k = 0; k < nd; k++) begin
      ed = exp_data.pop_front();
      chk_cnt++;
      if (obs_data[k] !== ed) $display("FAIL burst[%0d]: got %0d want %0d", k, obs_data[k], ed);
      else pass_cnt++;
    end
    chk_cnt++;
    if (dv_rises != 1) $display("FAIL burst_gaps: got %0d runs want 1", dv_rises); else pass_cnt++;
    nc = exp_cmd.size();
    chk_cnt++;
    if (obs_cmd.size() != nc) $display("FAIL cmd_count: got %0d want %0d", obs_cmd.size(), nc);
    else pass_cnt++;
    for (int k = 0; k < nc; k++) begin
      ec = exp_cmd.pop_front();
      chk_cnt++;
      if (obs_cmd[k] !== ec) $display("FAIL cmd[%0d]: got %h want %h", k, obs_cmd[k], ec);
      else pass_cnt++;
    end
    chk_cnt++;
    if (cv_bad != 0 || missed != 0) $display("FAIL cmd_window: got busy_hits=%0d missed=%0d want 0/0", cv_bad, missed);
    else pass_cnt++;
    chk_cnt++;
    if (finished !== 1'b1 || err !== 1'b0) $display("FAIL end_flags: got fin=%b err=%b want 1/0", finished, err);
    else pass_cnt++;
    chk_cnt++;
    if (heap_size !== 6'(nr)) $display("FAIL heap_size: got %0d want %0d", heap_size, nr); else pass_cnt++;
    for (int k = 0; k < nr; k++) begin
      @(negedge clk); rd_addr = 5'(k);
      @(posedge clk); #1;
      chk_cnt++;
      if (rd_data !== rsp[k]) $display("FAIL mem[%0d]: got %0d want %0d", k, rd_data, rsp[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    chk_cnt++;
    if (ld_ready !== 1'b1 || sc_ready !== 1'b1) $display("FAIL reset_ready: got %b%b want 11", ld_ready, sc_ready);
    else pass_cnt++;
    chk_cnt++;
    if ({mpq_data_valid, mpq_cmd_valid, finished, err} !== 4'b0000 || heap_size !== 6'd0 || rd_data !== 8'd0)
      $display("FAIL reset_outs: got dv=%b cv=%b fin=%b err=%b hs=%0d rd=%0d want zeros",
               mpq_data_valid, mpq_cmd_valid, finished, err, heap_size, rd_data);
    else pass_cnt++;
  endtask

  task automatic setup_build();
    d_a[0] = 8'd3; d_a[1] = 8'd9; d_a[2] = 8'd1; d_a[3] = 8'd7;
    s_a[0] = {3'd4, 8'd0, 8'd0};
    rsp[0] = 8'd9; rsp[1] = 8'd7; rsp[2] = 8'd1; rsp[3] = 8'd3; nr = 4;
  endtask

  task automatic test_build_write();
    do_reset();
    setup_build();
    drive_job(4, 1);
    wait_end();
    check_job(4);
  endtask

  task automatic test_extract();
    do_reset();
    d_a[0] = 8'd5; d_a[1] = 8'd2; d_a[2] = 8'd8;
    s_a[0] = {3'd1, 8'd0, 8'd0}; s_a[1] = {3'd4, 8'd0, 8'd0};
    rsp[0] = 8'd5; rsp[1] = 8'd2; nr = 2;
    drive_job(3, 2);
    wait_end();
    check_job(3);
  endtask

  task automatic test_insert_increase();
    do_reset();
    d_a[0] = 8'd4; d_a[1] = 8'd6;
    s_a[0] = {3'd3, 8'd0, 8'd10}; s_a[1] = {3'd2, 8'd2, 8'd12}; s_a[2] = {3'd4, 8'd0, 8'd0};
    rsp[0] = 8'd12; rsp[1] = 8'd10; rsp[2] = 8'd6; nr = 3;
    drive_job(2, 3);
    wait_end();
    check_job(2);
  endtask

  task automatic test_bad_script(input logic [2:0] op, input logic last);
    do_reset();
    @(negedge clk);
    ld_valid = 1'b1; ld_data = 8'd1; ld_last = 1'b0;
    sc_valid = 1'b1; sc_cmd = op; sc_index = 8'd0; sc_value = 8'd0; sc_last = last;
    @(posedge clk); #1;
    chk_cnt++;
    if (err !== 1'b1 || ld_ready !== 1'b0 || sc_ready !== 1'b0)
      $display("FAIL bad_script op%0d: got err=%b rdy=%b%b want 1/00", op, err, ld_ready, sc_ready);
    else pass_cnt++;
    @(negedge clk);
    ld_valid = 1'b0; sc_valid = 1'b0; sc_last = 1'b0;
    repeat (20) @(negedge clk);
    chk_cnt++;
    if (obs_data.size() != 0 || err !== 1'b1 || mpq_cmd_valid !== 1'b0)
      $display("FAIL bad_script_hold: got beats=%0d err=%b cv=%b want 0/1/0", obs_data.size(), err, mpq_cmd_valid);
    else pass_cnt++;
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < 33; k++) begin
      @(negedge clk);
      ld_valid = 1'b1; ld_data = 8'(k); ld_last = 1'b0;
      @(posedge clk); #1;
      if (k == 31) begin
        chk_cnt++;
        if (err !== 1'b0 || ld_ready !== 1'b1) $display("FAIL ovf_32: got err=%b rdy=%b want 0/1", err, ld_ready);
        else pass_cnt++;
      end
      if (k == 32) begin
        chk_cnt++;
        if (err !== 1'b1 || ld_ready !== 1'b0) $display("FAIL ovf_33: got err=%b rdy=%b want 1/0", err, ld_ready);
        else pass_cnt++;
      end
    end
    @(negedge clk);
    ld_valid = 1'b0;
  endtask

  task automatic test_reset_mid_stream();
    int t;
    do_reset();
    setup_build();
    drive_job(4, 1);
    t = 0;
    while (obs_data.size() < 2 && t < 50) begin @(negedge clk); t++; end
    chk_cnt++;
    if (t >= 50) $display("FAIL mid_wait: got %0d beats want 2", obs_data.size()); else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_cnt++;
    if (ld_ready !== 1'b1 || sc_ready !== 1'b1 || mpq_data_valid !== 1'b0 || err !== 1'b0 ||
        finished !== 1'b0 || heap_size !== 6'd0 || rd_data !== 8'd0)
      $display("FAIL mid_reset: got rdy=%b%b dv=%b err=%b fin=%b hs=%0d rd=%0d want reset values",
               ld_ready, sc_ready, mpq_data_valid, err, finished, heap_size, rd_data);
    else pass_cnt++;
    test_build_write();
  endtask

  initial begin
    test_reset();
    test_build_write();
    test_extract();
    test_insert_increase();
    test_bad_script(3'd1, 1'b1);
    test_bad_script(3'd5, 1'b0);
    test_overflow();
    test_reset_mid_stream();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
